// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-line instruction cache with single-outstanding MC refill
module icache #(
    parameter int IDX_W     = 8,
    parameter int REG_DAT_W = 32,
    parameter int INS_DAT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iIF_En,
    input  logic [REG_DAT_W-1:0] iIF_Pc,
    output logic                 oIF_En,
    output logic [INS_DAT_W-1:0] oIF_Ins,
    output logic                 oMC_En,
    output logic [REG_DAT_W-1:0] oMC_Addr,
    input  logic                 iMC_En,
    input  logic [INS_DAT_W-1:0] iMC_Dat
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = REG_DAT_W - IDX_W - 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                 state;
    logic [LINES-1:0]       valid_q;
    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [INS_DAT_W-1:0]   data_mem [LINES];

    // Latched fetch PC (word part only; byte offset never matters)
    logic [REG_DAT_W-3:0]   pc_q;

    logic [IDX_W-1:0]       req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       lat_idx;
    logic [TAG_W-1:0]       lat_tag;
    logic                   req_hit;
    logic                   fill;

    assign req_idx = iIF_Pc[IDX_W+1:2];
    assign req_tag = iIF_Pc[REG_DAT_W-1:IDX_W+2];
    assign lat_idx = pc_q[IDX_W-1:0];
    assign lat_tag = pc_q[REG_DAT_W-3:IDX_W];
    assign req_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign fill    = en && (state == ST_WAIT) && iMC_En;

    // Control FSM, valid bits and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            valid_q  <= '0;
            pc_q     <= '0;
            oIF_En   <= 1'b0;
            oIF_Ins  <= '0;
            oMC_En   <= 1'b0;
            oMC_Addr <= '0;
        end else if (en) begin
            oIF_En <= 1'b0;
            oMC_En <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iIF_En) begin
                        pc_q <= iIF_Pc[REG_DAT_W-1:2];
                        if (req_hit) begin
                            oIF_Ins <= data_mem[req_idx];
                            oIF_En  <= 1'b1;
                        end else begin
                            oMC_En   <= 1'b1;
                            oMC_Addr <= iIF_Pc & ~REG_DAT_W'(3);
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (iMC_En) begin
                        valid_q[lat_idx] <= 1'b1;
                        oIF_Ins          <= iMC_Dat;
                        oIF_En           <= 1'b1;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tag/data arrays are not reset; a line is only trusted once its valid bit is set
    always_ff @(posedge clk) begin
        if (fill) begin
            data_mem[lat_idx] <= iMC_Dat;
            tag_mem[lat_idx]  <= lat_tag;
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache against a line-map reference model
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        iIF_En;
    logic [31:0] iIF_Pc;
    logic        oIF_En;
    logic [31:0] oIF_Ins;
    logic        oMC_En;
    logic [31:0] oMC_Addr;
    logic        iMC_En;
    logic [31:0] iMC_Dat;

    int total = 0;
    int bad   = 0;

    // Reference: per line, whether it holds a word and which word address it holds
    bit          ref_valid [256];
    logic [29:0] ref_wa    [256];
    logic [31:0] ref_data  [256];

    icache #(.IDX_W(8), .REG_DAT_W(32), .INS_DAT_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .iIF_En  (iIF_En),
        .iIF_Pc  (iIF_Pc),
        .oIF_En  (oIF_En),
        .oIF_Ins (oIF_Ins),
        .oMC_En  (oMC_En),
        .oMC_Addr(oMC_Addr),
        .iMC_En  (iMC_En),
        .iMC_Dat (iMC_Dat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
    endtask

    // One complete fetch: request, optional refill after lat edges, then one idle cycle
    task automatic fetch(input logic [31:0] pc, input int lat, input logic [31:0] dat, input bit noise);
        int          idx;
        logic [29:0] wa;
        bit          hit;
        wa  = pc[31:2];
        idx = int'(wa % 256);
        hit = ref_valid[idx] && (ref_wa[idx] == wa);
        iIF_En = 1'b1;
        iIF_Pc = pc;
        step;
        iIF_En = 1'b0;
        if (hit) begin
            chk("hit_if_en", {31'd0, oIF_En}, 32'd1);
            chk("hit_ins", oIF_Ins, ref_data[idx]);
            chk("hit_mc_en", {31'd0, oMC_En}, 32'd0);
        end else begin
            chk("miss_mc_en", {31'd0, oMC_En}, 32'd1);
            chk("miss_addr", oMC_Addr, {pc[31:2], 2'b00});
            chk("miss_if_en", {31'd0, oIF_En}, 32'd0);
            for (int k = 1; k < lat; k++) begin
                if (noise) begin
                    iIF_En = 1'($urandom % 2);
                    iIF_Pc = $urandom;
                end
                step;
                chk("wait_mc_en", {31'd0, oMC_En}, 32'd0);
                chk("wait_if_en", {31'd0, oIF_En}, 32'd0);
            end
            iMC_En  = 1'b1;
            iMC_Dat = dat;
            if (noise) begin
                iIF_En = 1'($urandom % 2);
                iIF_Pc = $urandom;
            end
            step;
            iMC_En = 1'b0;
            iIF_En = 1'b0;
            chk("fill_if_en", {31'd0, oIF_En}, 32'd1);
            chk("fill_ins", oIF_Ins, dat);
            ref_valid[idx] = 1'b1;
            ref_wa[idx]    = wa;
            ref_data[idx]  = dat;
        end
        step;
        chk("idle_if_en", {31'd0, oIF_En}, 32'd0);
        chk("idle_mc_en", {31'd0, oMC_En}, 32'd0);
    endtask

    initial begin
        logic [31:0] pc;
        rst     = 1'b1;
        en      = 1'b1;
        iIF_En  = 1'b0;
        iIF_Pc  = '0;
        iMC_En  = 1'b0;
        iMC_Dat = '0;
        model_clear();
        step;
        step;
        chk("rst_if_en", {31'd0, oIF_En}, 32'd0);
        chk("rst_if_ins", oIF_Ins, 32'd0);
        chk("rst_mc_en", {31'd0, oMC_En}, 32'd0);
        chk("rst_mc_addr", oMC_Addr, 32'd0);
        rst = 1'b0;
        step;

        // Cold miss, MC answers 3 cycles after the request pulse, then re-hit
        fetch(32'h0000_0100, 3, 32'h0000_0013, 1'b0);
        fetch(32'h0000_0100, 1, 32'h0, 1'b0);
        fetch(32'h0000_0103, 1, 32'h0, 1'b0);

        // Conflict: same index, different tag evicts the line
        fetch(32'h0000_0500, 2, 32'hDEAD_BEEF, 1'b0);
        fetch(32'h0000_0500, 1, 32'h0, 1'b0);
        fetch(32'h0000_0100, 1, 32'h0000_0013, 1'b0);

        // Stall while waiting on MC, then stall while the response pulse is up
        iIF_En = 1'b1;
        iIF_Pc = 32'h0000_0300;
        step;
        iIF_En = 1'b0;
        chk("st_req_mc_en", {31'd0, oMC_En}, 32'd1);
        chk("st_req_addr", oMC_Addr, 32'h0000_0300);
        en = 1'b0;
        repeat (4) begin
            step;
            chk("st_hold_mc_en", {31'd0, oMC_En}, 32'd1);
            chk("st_hold_addr", oMC_Addr, 32'h0000_0300);
            chk("st_hold_if_en", {31'd0, oIF_En}, 32'd0);
        end
        en = 1'b1;
        step;
        chk("st_rel_mc_en", {31'd0, oMC_En}, 32'd0);
        chk("st_rel_if_en", {31'd0, oIF_En}, 32'd0);
        iMC_En  = 1'b1;
        iMC_Dat = 32'hCAFE_F00D;
        step;
        iMC_En = 1'b0;
        chk("st_fill_if_en", {31'd0, oIF_En}, 32'd1);
        chk("st_fill_ins", oIF_Ins, 32'hCAFE_F00D);
        en = 1'b0;
        repeat (2) begin
            step;
            chk("st_pulse_held", {31'd0, oIF_En}, 32'd1);
            chk("st_ins_held", oIF_Ins, 32'hCAFE_F00D);
        end
        en = 1'b1;
        step;
        chk("st_pulse_clr", {31'd0, oIF_En}, 32'd0);
        ref_valid[8'hC0] = 1'b1;
        ref_wa[8'hC0]    = 30'h0C0;
        ref_data[8'hC0]  = 32'hCAFE_F00D;
        fetch(32'h0000_0300, 1, 32'h0, 1'b0);

        // Reset in the middle of a miss, then a stale MC response
        iIF_En = 1'b1;
        iIF_Pc = 32'h0000_0200;
        step;
        iIF_En = 1'b0;
        chk("rw_mc_en", {31'd0, oMC_En}, 32'd1);
        step;
        #2;
        rst = 1'b1;
        #1;
        chk("rw_async_mc_en", {31'd0, oMC_En}, 32'd0);
        chk("rw_async_addr", oMC_Addr, 32'd0);
        chk("rw_async_if_en", {31'd0, oIF_En}, 32'd0);
        chk("rw_async_ins", oIF_Ins, 32'd0);
        step;
        rst = 1'b0;
        model_clear();
        iMC_En  = 1'b1;
        iMC_Dat = 32'h0000_1234;
        step;
        iMC_En = 1'b0;
        chk("rw_stale_if_en", {31'd0, oIF_En}, 32'd0);
        chk("rw_stale_mc_en", {31'd0, oMC_En}, 32'd0);
        fetch(32'h0000_0200, 2, 32'h0000_5555, 1'b0);
        fetch(32'h0000_0100, 1, 32'h0000_0013, 1'b0);

        // Random fetches over a small address pool so hits and conflicts both occur
        for (int n = 0; n < 80; n++) begin
            pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 2)
               | 32'($urandom_range(0, 3)) | (32'($urandom % 2) << 31);
            fetch(pc, int'($urandom_range(1, 4)), $urandom, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
